unidade_controle_jogadas: RTL and testbench

//   Moore FSM that sequences the memory-game datapath: clears the address counter and play register,

---
 rtl/unidade_controle_jogadas.sv | 132 +++++++++++++
 tb/tb_unidade_controle_jogadas.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_jogadas.sv
// Control unit for the memory-game datapath. It clears the counter and register, then
// registers and checks each play, advances the address, and ends on success, error or timeout.
module unidade_controle_jogadas #(
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       igual,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    localparam int TCNT_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [TCNT_W-1:0] TCNT_FIM = TCNT_W'(TIMEOUT_CICLOS - 1);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARACAO  = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTOU = 4'hA,
        FIM_ERROU   = 4'hE,
        FIM_TIMEOUT = 4'hF
    } estado_t;

    estado_t           estado_q;
    estado_t           estado_d;
    logic [TCNT_W-1:0] tcnt_q;
    logic [TCNT_W-1:0] tcnt_d;
    logic [7:0]        saidas_q;
    logic [7:0]        saidas_d;

    // Output vector order: {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}
    function automatic logic [7:0] decodifica_saidas(input estado_t e);
        logic [7:0] s;
        s = 8'b0000_0000;
        case (e)
            INICIAL:     s = 8'b0000_0000;
            PREPARACAO:  s = 8'b1010_0000;
            ESPERA:      s = 8'b0000_0000;
            REGISTRA:    s = 8'b0001_0000;
            COMPARACAO:  s = 8'b0000_0000;
            PROXIMO:     s = 8'b0100_0000;
            FIM_ACERTOU: s = 8'b0000_1100;
            FIM_ERROU:   s = 8'b0000_1010;
            FIM_TIMEOUT: s = 8'b0000_1001;
            default:     s = 8'b0000_0000;
        endcase
        return s;
    endfunction

    // State, inactivity counter and output flops; reset forces INICIAL with all outputs low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= INICIAL;
            tcnt_q   <= '0;
            saidas_q <= 8'b0000_0000;
        end else begin
            estado_q <= estado_d;
            tcnt_q   <= tcnt_d;
            saidas_q <= saidas_d;
        end
    end

    // Next-state logic; a play arriving on the terminal count takes priority over the timeout.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL: begin
                if (iniciar) estado_d = PREPARACAO;
                else         estado_d = INICIAL;
            end
            PREPARACAO: estado_d = ESPERA;
            ESPERA: begin
                if (jogada_feita)          estado_d = REGISTRA;
                else if (tcnt_q == TCNT_FIM) estado_d = FIM_TIMEOUT;
                else                       estado_d = ESPERA;
            end
            REGISTRA: estado_d = COMPARACAO;
            COMPARACAO: begin
                if (!igual)    estado_d = FIM_ERROU;
                else if (fimC) estado_d = FIM_ACERTOU;
                else           estado_d = PROXIMO;
            end
            PROXIMO: estado_d = ESPERA;
            FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: begin
                if (iniciar) estado_d = PREPARACAO;
                else         estado_d = estado_q;
            end
            default: estado_d = INICIAL;
        endcase
    end

    // Counter only advances while staying in ESPERA, so it starts at zero on every entry.
    always_comb begin
        tcnt_d = '0;
        if (estado_q == ESPERA && estado_d == ESPERA) begin
            tcnt_d = tcnt_q + TCNT_W'(1);
        end else begin
            tcnt_d = '0;
        end
    end

    // Outputs are decoded from the next state so the flopped copy always matches estado_q.
    always_comb begin
        saidas_d = 8'b0000_0000;
        saidas_d = decodifica_saidas(estado_d);
    end

    assign zeraC     = saidas_q[7];
    assign contaC    = saidas_q[6];
    assign zeraR     = saidas_q[5];
    assign registraR = saidas_q[4];
    assign pronto    = saidas_q[3];
    assign acertou   = saidas_q[2];
    assign errou     = saidas_q[1];
    assign timeout   = saidas_q[0];
    assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_jogadas.sv
// Bench for unidade_controle_jogadas: directed scenarios plus randomized stimulus
// checked against a cycle-level model of the game rules.
module tb_unidade_controle_jogadas;

    localparam int TO = 100;

    localparam logic [3:0] S_INI  = 4'h0;
    localparam logic [3:0] S_PREP = 4'h1;
    localparam logic [3:0] S_ESP  = 4'h2;
    localparam logic [3:0] S_REG  = 4'h4;
    localparam logic [3:0] S_CMP  = 4'h5;
    localparam logic [3:0] S_PROX = 4'h6;
    localparam logic [3:0] S_OK   = 4'hA;
    localparam logic [3:0] S_ERR  = 4'hE;
    localparam logic [3:0] S_TOUT = 4'hF;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic iniciar = 1'b0;
    logic jogada_feita = 1'b0;
    logic igual = 1'b0;
    logic fimC = 1'b0;
    logic zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    int n_checks = 0;
    int n_fails = 0;
    int n_conta = 0;
    logic [3:0] m_state = S_INI;
    int m_t = 0;

    unidade_controle_jogadas #(.TIMEOUT_CICLOS(TO)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
        .igual(igual), .fimC(fimC), .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR),
        .registraR(registraR), .pronto(pronto), .acertou(acertou), .errou(errou),
        .timeout(timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // {db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}
    function automatic logic [11:0] obs();
        return {db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout};
    endfunction

    function automatic logic [11:0] expect_of(input logic [3:0] s);
        logic fim;
        fim = (s == S_OK) || (s == S_ERR) || (s == S_TOUT);
        return {s, s == S_PREP, s == S_PROX, s == S_PREP, s == S_REG,
                fim, s == S_OK, s == S_ERR, s == S_TOUT};
    endfunction

    // Game rules: m_t counts cycles already spent waiting for the current play.
    task automatic model_step();
        if (reset) begin
            m_state = S_INI;
            m_t = 0;
        end else begin
            case (m_state)
                S_INI:  if (iniciar) m_state = S_PREP;
                S_PREP: begin m_state = S_ESP; m_t = 0; end
                S_ESP: begin
                    if (jogada_feita) m_state = S_REG;
                    else if (m_t == TO - 1) m_state = S_TOUT;
                    else m_t = m_t + 1;
                end
                S_REG:  m_state = S_CMP;
                S_CMP:  m_state = !igual ? S_ERR : (fimC ? S_OK : S_PROX);
                S_PROX: begin m_state = S_ESP; m_t = 0; end
                S_OK, S_ERR, S_TOUT: if (iniciar) m_state = S_PREP;
                default: m_state = S_INI;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        if (contaC === 1'b1) n_conta++;
    endtask

    task automatic do_play(input logic ig, input logic fc);
        jogada_feita = 1'b1; igual = ig; fimC = fc;
        tick();
        jogada_feita = 1'b0;
        tick();
        tick();
        if (m_state == S_PROX) tick();
        fimC = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; iniciar = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (obs() !== expect_of(S_INI)) begin
                n_fails++; $display("FAIL reset_hold: got %h expected %h", obs(), expect_of(S_INI));
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (obs() !== expect_of(S_INI)) begin
                n_fails++; $display("FAIL reset_idle: got %h expected %h", obs(), expect_of(S_INI));
            end
        end
    endtask

    task automatic test_full_round();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        n_checks++;
        if (obs() !== expect_of(S_PREP)) begin
            n_fails++; $display("FAIL round_prep: got %h expected %h", obs(), expect_of(S_PREP));
        end
        tick();
        n_conta = 0;
        for (int p = 0; p < 16; p++) begin
            do_play(1'b1, p == 15);
            n_checks++;
            if (obs() !== expect_of(p == 15 ? S_OK : S_ESP)) begin
                n_fails++; $display("FAIL round_play%0d: got %h expected %h", p, obs(),
                                    expect_of(p == 15 ? S_OK : S_ESP));
            end
        end
        n_checks++;
        if (n_conta != 15) begin
            n_fails++; $display("FAIL round_contaC: got %0d expected 15", n_conta);
        end
    endtask

    task automatic test_error();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        n_conta = 0;
        do_play(1'b1, 1'b0);
        do_play(1'b1, 1'b0);
        do_play(1'b0, 1'b0);
        n_checks++;
        if (obs() !== expect_of(S_ERR)) begin
            n_fails++; $display("FAIL error_state: got %h expected %h", obs(), expect_of(S_ERR));
        end
        n_checks++;
        if (n_conta != 2) begin
            n_fails++; $display("FAIL error_contaC: got %0d expected 2", n_conta);
        end
    endtask

    task automatic test_restart();
        iniciar = 1'b1;
        tick();
        n_checks++;
        if (obs() !== expect_of(S_PREP)) begin
            n_fails++; $display("FAIL restart_prep: got %h expected %h", obs(), expect_of(S_PREP));
        end
        tick();
        iniciar = 1'b0;
        n_checks++;
        if (obs() !== expect_of(S_ESP)) begin
            n_fails++; $display("FAIL restart_espera: got %h expected %h", obs(), expect_of(S_ESP));
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < TO - 1; i++) tick();
        n_checks++;
        if (obs() !== expect_of(S_ESP)) begin
            n_fails++; $display("FAIL timeout_early: got %h expected %h", obs(), expect_of(S_ESP));
        end
        tick();
        n_checks++;
        if (obs() !== expect_of(S_TOUT)) begin
            n_fails++; $display("FAIL timeout_fire: got %h expected %h", obs(), expect_of(S_TOUT));
        end
        // Same wait, but the play lands on the terminal cycle.
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        for (int i = 0; i < TO - 1; i++) tick();
        jogada_feita = 1'b1;
        igual = 1'b1;
        tick();
        jogada_feita = 1'b0;
        n_checks++;
        if (obs() !== expect_of(S_REG)) begin
            n_fails++; $display("FAIL timeout_play_wins: got %h expected %h", obs(), expect_of(S_REG));
        end
    endtask

    task automatic test_async_reset();
        tick();
        n_checks++;
        if (obs() !== expect_of(S_CMP)) begin
            n_fails++; $display("FAIL areset_pre: got %h expected %h", obs(), expect_of(S_CMP));
        end
        #2 reset = 1'b1;
        #1;
        m_state = S_INI;
        m_t = 0;
        n_checks++;
        if (obs() !== expect_of(S_INI)) begin
            n_fails++; $display("FAIL areset_immediate: got %h expected %h", obs(), expect_of(S_INI));
        end
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (obs() !== expect_of(S_INI)) begin
            n_fails++; $display("FAIL areset_after: got %h expected %h", obs(), expect_of(S_INI));
        end
    endtask

    task automatic test_random();
        int bad;
        int jf_range;
        bad = 0;
        for (int c = 0; c < 4000; c++) begin
            jf_range = (c < 2000) ? 4 : 150;
            reset        = ($urandom_range(0, 199) == 0);
            iniciar      = ($urandom_range(0, 7) == 0);
            jogada_feita = ($urandom_range(0, jf_range - 1) == 0);
            igual        = ($urandom_range(0, 9) != 0);
            fimC         = ($urandom_range(0, 5) == 0);
            tick();
            n_checks++;
            if (obs() !== expect_of(m_state)) begin
                n_fails++;
                if (bad < 10) $display("FAIL random_cycle%0d: got %h expected %h", c, obs(), expect_of(m_state));
                bad++;
            end
        end
        reset = 1'b0; iniciar = 1'b0; jogada_feita = 1'b0; igual = 1'b0; fimC = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_round();
        test_error();
        test_restart();
        test_timeout();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
